spi_master: RTL
===============

# spi_master

SPI bus initiator that drives `sclk`, `ss` and `mosi` toward the `spi_slave` block and captures `miso` in return. It operates in mode 0 (CPOL=0, CPHA=0), transfers MSB first, and runs full-duplex words of `DATA_W` bits. It sits between a simple host start/done handshake and the external SPI pins. It is the counterpart that benches and SoC integration use to exercise `spi_slave` without a VPI-driven bus model.

## Interface
- `DATA_W`, 32: transfer word width in bits; must be at least 2.
- `CLK_DIV`, 8: `sclk` half-period in `clk` cycles; must be at least 2 so the synchronous slave sees every edge.

- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request a transfer; sampled only while idle.
- `data_in` in `DATA_W`: word to send; captured on the accepted `start`.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `data_out` out `DATA_W`: word received; valid from `done` until the next `done`.
- `sclk` out 1: SPI clock; idles low.
- `ss` out 1: slave select, active-low.
- `mosi` out 1: serial data to the slave.
- `miso` in 1: serial data from the slave.

## Operation
- **Reset values** (`rst`=0, immediate and asynchronous): `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `data_out`=0, state IDLE.
- **Counters**
  - `div_cnt` counts 0..`CLK_DIV`-1 in each timed state.
  - `bit_cnt` counts 0..`DATA_W`-1.
- **Shift registers**: `tx_sr` and `rx_sr`, each `DATA_W` bits.
- **IDLE**
  - Outputs: `ss`=1, `sclk`=0, `mosi`=0, `busy`=0.
  - On `start`=1: `tx_sr`<=`data_in`, `mosi`<=`data_in[DATA_W-1]`, `ss`<=0, `busy`<=1, counters cleared, go to LOW.
- **LOW**
  - Hold `sclk`=0 for `CLK_DIV` cycles.
  - On the terminal count: `sclk`<=1, `rx_sr`<={`rx_sr[DATA_W-2:0]`, `miso`}, go to HIGH.
- **HIGH**
  - Hold `sclk`=1 for `CLK_DIV` cycles.
  - On the terminal count: `sclk`<=0.
  - If `bit_cnt`==`DATA_W`-1: go to HOLD.
  - Otherwise: shift `tx_sr` left, `mosi`<= next bit, `bit_cnt`++, go to LOW.
- **HOLD**
  - `sclk`=0, `ss`=0, `mosi` keeps the LSB, for `CLK_DIV` cycles.
  - On the terminal count: `ss`<=1, `mosi`<=0, go to GAP.
- **GAP**
  - `ss`=1, `busy`=1, for `CLK_DIV` cycles.
  - On the terminal count: `data_out`<=`rx_sr`, `done`<=1, `busy`<=0, go to IDLE.
- `done` is 1 for exactly one cycle.
- **Start rules**
  - `start` is ignored in every state except IDLE; there is no queuing.
  - `data_in` changes while busy have no effect.
  - `start` held high produces back-to-back transfers. The next accept happens on the first IDLE cycle, one cycle after the `done` edge. `ss` therefore stays high for `CLK_DIV`+1 cycles between words.
- **Reset mid-transfer**: aborts immediately to the reset values. `data_out` clears to 0 and no `done` is issued.

## Timing
Let `start` be accepted at rising edge k. Let N=`DATA_W` and D=`CLK_DIV`.
- **Edge k**: `ss` falls; `mosi`=bit N-1; `busy` rises.
- **Rising `sclk` edges**: the n-th (n=0..N-1) occurs at edge k+(2n+1)D. `miso` is sampled as the value present in the cycle before that edge.
- **Falling `sclk` edges**: the n-th occurs at k+(2n+2)D. `mosi` updates to bit N-2-n on the same edge, for n<N-1.
- **End of frame**
  - Last falling edge: k+2ND.
  - `ss` rises: k+(2N+1)D.
  - `done`=1, `busy`=0 and `data_out` valid: k+(2N+2)D. With defaults this is k+528.
- **Duty cycle**: `sclk` is high D and low D cycles, 50%. Frequency is `clk`/(2D).
- **Bit order**: MSB is transmitted and received first. `rx_sr` bit 0 holds the last sampled bit.

## Test plan
1. **Reset**: assert `rst`=0 mid-transfer (bit 10) → same cycle `ss`=1, `sclk`=0, `mosi`=0, `busy`=0. No `done` follows, `data_out`=0.
2. **Loopback**: `miso`=`mosi`, `data_in`=0xA5A50F3C, `start` pulse → 32 `sclk` rising edges, `done` 528 cycles after accept, `data_out`=0xA5A50F3C.
3. **Bit order**: `data_in`=0x80000001, `miso` tied 1.
   - `mosi` is 1 at rising edge 0, 0 at edges 1..30, 1 at edge 31.
   - `data_out`=0xFFFFFFFF.
4. **Busy lockout**: a `start` pulse with `data_in`=0x12345678 arrives at cycle 100 of a transfer of 0x0 with loopback → it is ignored. Only one `done`, `data_out`=0x00000000.
5. **Back-to-back**: `start` held high, `data_in`=0x0000FFFF, loopback.
   - Second `ss` fall comes 1 cycle after the first `done`.
   - Each `ss`-high gap is 9 cycles.
   - Each `done` returns 0x0000FFFF.
6. **Parameters**: `DATA_W`=8, `CLK_DIV`=2, slave model returning 0x3C → `done` 36 cycles after accept, `data_out`=0x3C, `sclk` period 4 `clk`.

Source files
------------

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI mode-0 (CPOL=0, CPHA=0) initiator, MSB first, full-duplex
//               words of DATA_W bits. Host side is a start/done handshake.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous reset, active-low
//               start    - transfer request, sampled only while idle
//               data_in  - word to transmit, captured on accepted start
//               busy     - transfer in progress
//               done     - one-cycle pulse at end of transfer
//               data_out - received word, valid from done to next done
//               sclk     - SPI clock, idles low
//               ss       - slave select, active-low
//               mosi     - serial data to slave
//               miso     - serial data from slave
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_BIT_W = $clog2(DATA_W);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_HOLD = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_ss;
    logic                r_mosi;

    logic                w_div_last;

    // Every timed state lasts exactly CLK_DIV cycles; the action of a state
    // happens on the edge where the divider sits at its terminal count.
    assign w_div_last = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ss   <= 1'b1;
                    r_sclk <= 1'b0;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_tx_sr   <= data_in;
                        r_mosi    <= data_in[DATA_W-1];
                        r_ss      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b1;
                        // Sample on the rising edge: the value present in the
                        // cycle before this edge is what gets captured.
                        r_rx_sr   <= {r_rx_sr[DATA_W-2:0], miso};
                        r_state   <= S_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            // mosi keeps the LSB through HOLD
                            r_state <= S_HOLD;
                        end else begin
                            r_tx_sr   <= {r_tx_sr[DATA_W-2:0], 1'b0};
                            r_mosi    <= r_tx_sr[DATA_W-2];
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                            r_state   <= S_LOW;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        r_ss      <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_state   <= S_GAP;
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_div_last) begin
                        r_div_cnt  <= '0;
                        r_data_out <= r_rx_sr;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data_out;
    assign sclk     = r_sclk;
    assign ss       = r_ss;
    assign mosi     = r_mosi;

endmodule
`default_nettype wire
